// File: rtl/mod23_pkg.sv
// Shared constants and types for the mod-23 multi-word residue accumulator.
package mod23_pkg;

  localparam int MOD23_MODULUS   = 23;
  localparam int MOD23_RADIX_RES = 9;   // 2^16 mod 23
  localparam int RES_W           = 5;

  typedef logic [RES_W-1:0] res_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/mod23_stream_acc_if.sv
// Beat-in / result-out handshake bundle of the mod-23 stream accumulator.
interface mod23_stream_acc_if;
  import mod23_pkg::*;

  logic in_valid;
  logic in_ready;
  res_t in_r;
  logic in_last;
  logic out_valid;
  logic out_ready;
  res_t out_r;
  logic err_res;
  logic err_len;

  modport master (
    output in_valid, in_r, in_last, out_ready,
    input  in_ready, out_valid, out_r, err_res, err_len
  );

  modport slave (
    input  in_valid, in_r, in_last, out_ready,
    output in_ready, out_valid, out_r, err_res, err_len
  );

endinterface

// File: rtl/mod23_reduce8.sv
// Combinational 8-bit to mod-23 reduction by conditional subtraction of 8, 4, 2 and 1 times 23.
module mod23_reduce8
  import mod23_pkg::*;
(
  input  logic [7:0] sum,
  output res_t       res
);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;
  logic [7:0] s4;

  // Each stage leaves a value below the next subtrahend, ending in 0..22.
  assign s1  = (sum >= 8'd184) ? sum - 8'd184 : sum;
  assign s2  = (s1  >= 8'd92)  ? s1  - 8'd92  : s1;
  assign s3  = (s2  >= 8'd46)  ? s2  - 8'd46  : s2;
  assign s4  = (s3  >= 8'd23)  ? s3  - 8'd23  : s3;
  assign res = s4[RES_W-1:0];

endmodule

// File: rtl/mod23_stream_acc.sv
// Folds per-word mod-23 residues (MSW first) into the residue of the whole message.
module mod23_stream_acc
  import mod23_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int MODULUS   = MOD23_MODULUS,
  parameter int RADIX_RES = MOD23_RADIX_RES
)(
  input logic               clk,
  input logic               rst_n,
  mod23_stream_acc_if.slave bus
);

  logic [1:0] state;
  res_t       acc;
  logic [7:0] cnt;
  logic       err_res_q;
  logic       err_len_q;

  logic       accept;
  logic [7:0] sum;
  res_t       acc_next;
  logic [7:0] cnt_next;
  logic       bad_res;
  logic       len_hit;

  assign accept   = bus.in_valid && bus.in_ready;
  // Out-of-range residues enter the sum unreduced; 9*22+31 still fits 8 bits.
  assign sum      = 8'(RADIX_RES) * {3'b000, acc} + {3'b000, bus.in_r};
  assign cnt_next = cnt + 8'd1;
  assign bad_res  = (bus.in_r >= RES_W'(MODULUS));
  assign len_hit  = (cnt_next == 8'(MAX_WORDS)) && !bus.in_last;

  mod23_reduce8 u_reduce (
    .sum (sum),
    .res (acc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      err_res_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (accept) begin
            acc       <= acc_next;
            err_res_q <= err_res_q | bad_res;
            if (bus.in_last) begin
              state <= ST_OUT;
            end else if (len_hit) begin
              state     <= ST_OUT;
              cnt       <= cnt_next;
              err_len_q <= 1'b1;
            end else begin
              state <= ST_ACC;
              cnt   <= cnt_next;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            err_res_q <= 1'b0;
            err_len_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The result is only presented while holding it in OUT.
  assign bus.in_ready  = (state != ST_OUT);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.out_r     = (state == ST_OUT) ? acc : '0;
  assign bus.err_res   = err_res_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_mod23_stream_acc.sv
// Self-checking bench: directed scenarios plus random messages against a big-number residue model.
module tb_mod23_stream_acc;
  import mod23_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod23_stream_acc_if bus ();

  mod23_stream_acc #(.MAX_WORDS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int model_res;
  bit model_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_msg();
    model_res = 0;
    model_err = 0;
  endtask

  // Drive one beat at the falling edge; v is the numeric value the beat stands for.
  task automatic send(input logic [4:0] r, input bit last, input int v);
    bus.in_valid = 1'b1;
    bus.in_r     = r;
    bus.in_last  = last;
    check("beat_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    model_res = (model_res * 65536 + v) % 23;
    if (r >= 5'd23) model_err = 1;
  endtask

  task automatic send_word(input bit last);
    int w;
    w = int'($urandom_range(0, 65535));
    send(5'(w % 23), last, w);
  endtask

  task automatic send_res(input int r, input bit last);
    send(5'(r), last, r);
  endtask

  task automatic expect_out(input string tag, input bit e_len);
    bus.in_valid = 1'b0;
    check({tag, "_valid"},    bus.out_valid, 1);
    check({tag, "_r"},        bus.out_r, model_res);
    check({tag, "_err_res"},  bus.err_res, model_err);
    check({tag, "_err_len"},  bus.err_len, e_len);
    check({tag, "_in_ready"}, bus.in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_done_valid"}, bus.out_valid, 0);
    check({tag, "_done_ready"}, bus.in_ready, 1);
    check({tag, "_done_err"},   {bus.err_res, bus.err_len}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    bus.in_valid  = 1'b0;
    bus.in_r      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_r",     bus.out_r, 0);
    check("rst_errs",      {bus.err_res, bus.err_len}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // Single beat 5
    start_msg();
    send_res(5, 1);
    expect_out("single5", 0);
    check("single5_lit", bus.out_r, 5);
    handshake("single5");

    // 1 then 0 -> 65536 mod 23
    start_msg();
    send_res(1, 0);
    send_res(0, 1);
    expect_out("radix", 0);
    check("radix_lit", bus.out_r, 9);
    handshake("radix");

    // 22,22,22 back to back
    start_msg();
    send_res(22, 0);
    send_res(22, 0);
    send_res(22, 1);
    expect_out("max3", 0);
    check("max3_lit", bus.out_r, 1);
    handshake("max3");

    // Backpressure: outputs hold, pending beat waits for the handoff
    start_msg();
    send_word(0);
    send_word(0);
    send_word(1);
    expect_out("hold", 0);
    bus.in_valid = 1'b1;
    bus.in_r     = 5'd7;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_r",     bus.out_r, model_res);
      check("hold_ready", bus.in_ready, 0);
      check("hold_errs",  {bus.err_res, bus.err_len}, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_done_valid", bus.out_valid, 0);
    check("hold_done_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("hold_next_valid", bus.out_valid, 1);
    check("hold_next_r",     bus.out_r, 7);
    handshake("hold_next");

    // Out-of-range residue
    start_msg();
    send_res(25, 1);
    expect_out("bad25", 0);
    check("bad25_lit", bus.out_r, 2);
    handshake("bad25");
    start_msg();
    send_word(0);
    send_res(31, 0);
    send_word(1);
    expect_out("badmid", 0);
    handshake("badmid");

    // Truncation at MAX_WORDS
    start_msg();
    for (int i = 0; i < 15; i++) send_word(0);
    check("trunc15_valid", bus.out_valid, 0);
    send_word(0);
    expect_out("trunc16", 1);
    handshake("trunc16");
    start_msg();
    send_res(4, 1);
    expect_out("after_trunc", 0);
    handshake("after_trunc");

    // Reset mid-message
    start_msg();
    send_res(3, 0);
    send_res(25, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_r",     bus.out_r, 0);
    check("midrst_errs",  {bus.err_res, bus.err_len}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_msg();
    send_res(7, 1);
    expect_out("postrst", 0);
    check("postrst_lit", bus.out_r, 7);
    handshake("postrst");

    // Random messages with occasional bad residues and random backpressure
    for (int m = 0; m < 30; m++) begin
      start_msg();
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) send_res(int'($urandom_range(23, 31)), i == len - 1);
        else send_word(i == len - 1);
      end
      expect_out("rand", 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        @(negedge clk);
        check("rand_hold_r", bus.out_r, model_res);
      end
      handshake("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mod23_stream_acc.md
MOD23_STREAM_ACC -- requirements
Module: mod23_stream_acc

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 16, meaning the maximum number of beats per message (range 1..255).
REQ-002 SHALL have parameter MODULUS, default 23, meaning the divisor; the implementation only needs to support 23.
REQ-003 SHALL have parameter RADIX_RES, default 9, meaning 2^16 mod MODULUS.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream per-word residue beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_r  input  5  residue mod 23 of one 16-bit word; most-significant word first.
REQ-009 in_last  input  1  beat is the final (least-significant) word of the message.
REQ-010 out_valid  output  1  message residue available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_r  output  5  residue mod 23 of the whole multi-word message.
REQ-013 err_res  output  1  some beat of this message carried in_r >= 23.
REQ-014 err_len  output  1  message was truncated at MAX_WORDS beats without in_last.

Function
REQ-015 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 FSM states SHALL be IDLE, ACC and OUT; in_ready=1 in IDLE and ACC, and in_ready=0 in OUT.
REQ-017 On an accepted beat, acc SHALL update to (RADIX_RES*acc + in_r) mod 23, with acc=0 at message start (IDLE).
REQ-018 The intermediate sum SHALL be 8 bits wide (max 9*22+31=229) and SHALL be reduced by a combinational mod-23 in the same cycle.
REQ-019 An accepted beat with in_last=0 SHALL move IDLE->ACC and keep ACC, and SHALL increment the 8-bit beat counter.
REQ-020 An accepted beat with in_last=1 SHALL move to OUT, and out_valid SHALL rise the next cycle with out_r equal to the final acc (latency 1 cycle).
REQ-021 If the counter reaches MAX_WORDS with in_last=0 on that beat, the block SHALL go to OUT with err_len=1; later beats belong to a new message.
REQ-022 When in_r >= 23, the value SHALL still be used unreduced in the sum, and err_res SHALL be set and held sticky until the message is delivered.
REQ-023 In OUT, out_r, out_valid, err_res and err_len SHALL hold stable while out_ready=0.
REQ-024 In OUT with out_ready=1, the state SHALL go to IDLE the next cycle with acc, counter and error flags cleared and out_valid=0.
REQ-025 No beat SHALL be accepted in the same cycle as the result handoff.
REQ-026 out_valid SHALL never be asserted in IDLE or ACC.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force state IDLE, acc=0, counter=0, out_valid=0, out_r=0, err_res=0 and err_len=0; in_ready SHALL be 1 once reset is deasserted.
REQ-028 Reset mid-message SHALL discard all partial state; the first beat after deassertion SHALL start a new message.

Structure
REQ-029 MODULUS, RADIX_RES, the residue width (5) and the FSM state encoding SHALL live in shared package mod23_pkg.
REQ-030 The combinational 8-bit-to-mod-23 reducer SHALL be a sub-module named mod23_reduce8.
REQ-031 The input side SHALL connect directly to the registered residue output of the 16-bit mod-23 stage.

Verification
REQ-032 Single beat in_r=5 with in_last=1 -> out_valid next cycle with out_r=5, err_res=0 and err_len=0.
REQ-033 Beats 1 then 0 (last) -> out_r=9 (65536 mod 23).
REQ-034 Beats 22, 22, 22 (last) -> out_r=1, and back-to-back beats SHALL be accepted every cycle in IDLE and ACC.
REQ-035 out_ready held 0 for 5 cycles in OUT -> outputs stable, in_ready=0, and the next message starts only after the handshake.
REQ-036 Beat in_r=25 -> err_res=1 on the result; 16 beats with no in_last -> out_valid with err_len=1.
REQ-037 rst_n pulsed low after 2 of 3 beats -> all outputs 0 immediately; a new single-beat message 7 then yields out_r=7.
